// File: rtl/muller_arbiter.sv
// Round-robin arbiter that multiplexes NREQ 4-phase requesters onto one
// Muller-pipeline input stage, with bundling margin and request timeout.
module muller_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NREQ-1:0]                          req,
    input  logic [NREQ*DW-1:0]                       data,
    output logic [NREQ-1:0]                          ack,
    output logic                                     out_req,
    output logic [DW-1:0]                            out_data,
    input  logic                                     res_ack,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                     busy,
    output logic                                     timeout_err
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = GW + 1;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_REQ_HI = 3'd2;
    localparam logic [2:0] S_ACK_HI = 3'd3;
    localparam logic [2:0] S_REQ_LO = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [DW-1:0]   odata_q, odata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            oreq_q, oreq_d;
    logic            terr_q, terr_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [DW-1:0]   data_arr [NREQ];
    logic [NREQ-1:0] own_sel;
    logic            own_req;
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [CW-1:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign data_arr[gi] = data[gi*DW +: DW];
            assign own_sel[gi]  = (grant_q == GW'(gi));
        end
    endgenerate

    assign own_req = |(req & own_sel);

    // Search starts one past the previous owner and wraps, so a freshly
    // served (or timed-out) requester is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_found && req[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        odata_d = odata_q;
        ack_d   = ack_q;
        oreq_d  = oreq_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A stage still holding res_ack has not returned to zero yet.
                if (win_found && !res_ack) begin
                    state_d = S_SETUP;
                    grant_d = win_idx;
                    last_d  = win_idx;
                    odata_d = data_arr[win_idx];
                    cnt_d   = '0;
                    oreq_d  = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_REQ_HI;
                oreq_d  = 1'b1;
            end
            S_REQ_HI: begin
                cnt_d = cnt_q + 8'd1;
                if (res_ack) begin
                    state_d = S_ACK_HI;
                    ack_d   = own_sel;
                end else if (cnt_q + 8'd1 >= TO_LIMIT) begin
                    state_d = S_IDLE;
                    oreq_d  = 1'b0;
                    terr_d  = 1'b1;
                end
            end
            S_ACK_HI: begin
                if (!own_req) begin
                    state_d = S_REQ_LO;
                    oreq_d  = 1'b0;
                end
            end
            S_REQ_LO: begin
                if (!res_ack) begin
                    state_d = S_IDLE;
                    ack_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                oreq_d  = 1'b0;
                ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NREQ - 1);
            odata_q <= '0;
            ack_q   <= '0;
            oreq_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            odata_q <= odata_d;
            ack_q   <= ack_d;
            oreq_q  <= oreq_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign out_req     = oreq_q;
    assign out_data    = odata_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_muller_arbiter.sv
// Scenario bench for muller_arbiter: the bench plays both the requesters and
// the shared stage; grant order comes from a modular round-robin model.
module tb_muller_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 2;
    localparam int TIMEOUT = 15;
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] data = '0;
    logic              res_ack = 1'b0;
    logic [NREQ-1:0]   ack;
    logic              out_req;
    logic [DW-1:0]     out_data;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int last_m = NREQ - 1;

    muller_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .ack         (ack),
        .out_req     (out_req),
        .out_data    (out_data),
        .res_ack     (res_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Next owner: first pending requester after the previous owner, modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        int pick;
        pick = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (pick < 0 && p[(last + k) % NREQ]) pick = (last + k) % NREQ;
        end
        return pick;
    endfunction

    task automatic raise(input int i, input logic [DW-1:0] d);
        data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic raise_mask(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++) begin
            if (m[i] && !req[i]) raise(i, DW'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; res_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_m = NREQ - 1;
        @(negedge clk);
    endtask

    // One full 4-phase transaction with the bench acting as the shared stage.
    task automatic serve(input int dly, input logic [NREQ-1:0] extra, output int got);
        int exp_id, waited;
        logic [DW-1:0] exp_d;
        logic [NREQ-1:0] exp_ack;
        exp_id = rr_pick(req, last_m);
        if (exp_id < 0) exp_id = 0;
        exp_d = data[exp_id*DW +: DW];
        exp_ack = '0;
        exp_ack[exp_id] = 1'b1;
        waited = 0;
        while (out_req !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (out_req !== 1'b1) begin n_bad++; $display("FAIL serve_out_req_rise: got %b want 1", out_req); end
        got = int'(grant_id);
        n_cmp++;
        if (grant_id !== GW'(exp_id)) begin n_bad++; $display("FAIL serve_grant: got %0d want %0d", grant_id, exp_id); end
        n_cmp++;
        if (out_data !== exp_d) begin n_bad++; $display("FAIL serve_out_data: got %b want %b", out_data, exp_d); end
        for (int i = 0; i < NREQ; i++) begin
            if (extra[i] && i != exp_id && !req[i]) raise(i, DW'($urandom));
        end
        repeat (dly) @(negedge clk);
        res_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack !== exp_ack) begin n_bad++; $display("FAIL serve_ack_rise: got %b want %b", ack, exp_ack); end
        n_cmp++;
        if (out_data !== exp_d) begin n_bad++; $display("FAIL serve_data_hold: got %b want %b", out_data, exp_d); end
        req[exp_id] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b0 || ack !== exp_ack) begin
            n_bad++; $display("FAIL serve_req_lo: got out_req=%b ack=%b want 0 %b", out_req, ack, exp_ack);
        end
        res_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== '0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL serve_close: got ack=%b busy=%b want 0 0", ack, busy);
        end
        last_m = exp_id;
        $display("txn grant=%0d data=%b stage_delay=%0d pending=%b", exp_id, exp_d, dly, req);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({ack, out_req, out_data, grant_id, busy, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got ack=%b oreq=%b od=%b gid=%0d busy=%b terr=%b want all 0",
                     ack, out_req, out_data, grant_id, busy, timeout_err);
        end
        rst = 1'b1;
        last_m = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int got;
        raise(0, 2'b10);
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_setup: got out_req=%b busy=%b want 0 1", out_req, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b1 || out_data !== 2'b10) begin
            n_bad++; $display("FAIL single_latency: got out_req=%b data=%b want 1 10", out_req, out_data);
        end
        serve(2, '0, got);
    endtask

    task automatic test_contention();
        int got;
        int order [3] = '{0, 1, 3};
        do_reset();
        raise_mask(4'b1011);
        for (int t = 0; t < 3; t++) begin
            serve($urandom_range(0, 4), '0, got);
            n_cmp++;
            if (got !== order[t]) begin n_bad++; $display("FAIL contention_order: got %0d want %0d", got, order[t]); end
        end
    endtask

    task automatic test_fairness();
        int got;
        int order [4] = '{0, 2, 0, 2};
        raise_mask(4'b0101);
        for (int t = 0; t < 4; t++) begin
            serve($urandom_range(0, 4), '0, got);
            n_cmp++;
            if (got !== order[t]) begin n_bad++; $display("FAIL fairness_order: got %0d want %0d", got, order[t]); end
            if (t < 3) raise(got, DW'($urandom));
        end
        serve(1, '0, got);
    endtask

    task automatic test_timeout();
        int waited, hi;
        raise(2, DW'($urandom));
        waited = 0;
        while (out_req !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        hi = 0;
        while (out_req === 1'b1 && hi < 40) begin @(negedge clk); hi++; end
        n_cmp++;
        if (hi != TIMEOUT) begin n_bad++; $display("FAIL timeout_len: got %0d want %0d", hi, TIMEOUT); end
        n_cmp++;
        if (timeout_err !== 1'b1 || ack !== '0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_abort: got terr=%b ack=%b busy=%b want 1 0 0", timeout_err, ack, busy);
        end
        req[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_pulse_width: got terr=%b busy=%b want 0 0", timeout_err, busy);
        end
        last_m = 2;
        $display("txn timeout requester=2 req_hi_cycles=%0d", hi);
    endtask

    task automatic test_violation();
        int waited, exp_id;
        raise(3, DW'($urandom));
        exp_id = rr_pick(req, last_m);
        waited = 0;
        while (out_req !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        n_cmp++;
        if (grant_id !== GW'(exp_id)) begin n_bad++; $display("FAIL violation_grant: got %0d want %0d", grant_id, exp_id); end
        req[3] = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b1 || ack !== '0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL violation_wait: got oreq=%b ack=%b busy=%b want 1 0 1", out_req, ack, busy);
        end
        res_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack !== 4'b1000) begin n_bad++; $display("FAIL violation_ack: got %b want 1000", ack); end
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b0) begin n_bad++; $display("FAIL violation_req_lo: got %b want 0", out_req); end
        res_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== '0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL violation_close: got ack=%b busy=%b want 0 0", ack, busy);
        end
        last_m = exp_id;
        $display("txn violation grant=%0d", exp_id);
    endtask

    task automatic test_stale();
        int got;
        res_ack = 1'b1;
        raise(0, DW'($urandom));
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || out_req !== 1'b0) begin
                n_bad++; $display("FAIL stale_hold: got busy=%b oreq=%b want 0 0", busy, out_req);
            end
        end
        res_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || out_req !== 1'b0) begin
            n_bad++; $display("FAIL stale_setup: got busy=%b oreq=%b want 1 0", busy, out_req);
        end
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b1) begin n_bad++; $display("FAIL stale_req_hi: got %b want 1", out_req); end
        serve(1, '0, got);
    endtask

    task automatic test_reset_midop();
        int waited, got;
        raise(0, DW'($urandom));
        waited = 0;
        while (out_req !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        res_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack !== 4'b0001) begin n_bad++; $display("FAIL midop_ack_hi: got %b want 0001", ack); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (ack !== '0 || out_req !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL midop_async_clear: got ack=%b oreq=%b busy=%b gid=%0d od=%b want all 0",
                     ack, out_req, busy, grant_id, out_data);
        end
        req = '0;
        res_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_m = NREQ - 1;
        @(negedge clk);
        raise(1, DW'($urandom));
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL midop_setup: got oreq=%b busy=%b want 0 1", out_req, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (out_req !== 1'b1 || grant_id !== GW'(1)) begin
            n_bad++; $display("FAIL midop_regrant: got oreq=%b gid=%0d want 1 1", out_req, grant_id);
        end
        serve(1, '0, got);
    endtask

    task automatic test_random();
        int got;
        for (int t = 0; t < 25; t++) begin
            if (req == '0) raise_mask(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            serve($urandom_range(0, 8), NREQ'($urandom), got);
        end
        while (req != '0) serve($urandom_range(0, 3), '0, got);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_violation();
        test_stale();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
